rst_sequencer: RTL and testbench
================================

Name: rst_sequencer

Overview:
Parametrised successor to the single-vector reset controller. Drives N_DOMAIN active-low reset domains with a stretched global assert and a staggered per-domain release. Adds per-domain software pulse resets and a saturating reset counter, and keeps the CAUSE/INFO bus registers. Sits on the peripheral bus at the RST window and takes SoC fault reports from the core.

Parameters:
N_DOMAIN, 4, number of reset domains (1..16); domain 0 is released first.
STRETCH_CYC, 16, cycles all domains stay asserted after a trigger, and the length of a domain pulse (>=1).
STAGGER_CYC, 4, cycles between successive domain releases (>=1).

Ports:
clk  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
rst_ob  out  N_DOMAIN  per-domain reset, lo active
soc_fault  in  1  fault pulse from core
soc_fault_cause  in  8  fault cause code
soc_fault_addr  in  `XLEN  faulting address
addr  in  $clog2(`RST_SIZE)  byte address in window (`RST_SIZE >= 16)
w_rb  in  1  1 = write, 0 = read
acc  in  `BUS_ACC_WIDTH  access size
rdata  out  `BUS_WIDTH  read data, registered
wdata  in  `BUS_WIDTH  write data
req  in  1  access request
resp  out  1  access done, one cycle after a valid req
fault  out  1  invalid access, combinational, same cycle as req

Behaviour:
- Register map (name, addr, size, access):
  - RST, 0, 2B, W: bit0 triggers a global SW reset.
  - CAUSE, 2, 2B, R: bits7:0 hold the cause.
  - INFO, 4, 4B, RW: fault address or software scratch.
  - DRST, 8, 4B, W: bits[N_DOMAIN-1:0] start domain pulses.
  - STAT, 12, 4B, R: bits[N_DOMAIN-1:0] = 1 when the domain is in reset; bits23:16 = reset count.
- Invalid access (fault=req&invld, no resp, no side effects):
  - address not in {0, 2, 4, 8, 12};
  - acc not `BUS_ACC_2B for addr 0/2, or not `BUS_ACC_4B for addr 4/8/12;
  - write to CAUSE or STAT, or read of RST or DRST.
- Valid access: resp=1 on the next cycle. Read rdata is captured at the req edge and zero-extended. Bus accesses are served in every FSM state.
- rst_i asserted, asynchronously:
  - rst_ob=0, state=ASSERT, cnt=STRETCH_CYC-1;
  - cause=`RST_CAUSE_HW, count=0, resp=0, rdata=0, all domain pulse counters cleared.
  - INFO is unchanged.
- FSM:
  - ASSERT: all rst_ob low. cnt counts down; at 0, go to RELEASE with idx=0, scnt=0.
  - RELEASE: deassert domain idx when scnt==0, then reload scnt=STAGGER_CYC-1 and idx++. After domain N_DOMAIN-1, go to RUN.
  - RUN: idle; domain pulses are allowed.
- Trigger timing: a trigger sampled at edge T, or the first edge with rst_i low, gives:
  - rst_ob=all 0 from T+1 for STRETCH_CYC cycles;
  - domain k high at T+1+STRETCH_CYC+k*STAGGER_CYC.
- Global triggers:
  - valid RST write with wdata[0]=1 sets cause=`RST_CAUSE_SW;
  - soc_fault sets cause=soc_fault_cause and INFO=soc_fault_addr.
  - Both go to ASSERT, reload cnt, clear pulses, and increment count (saturating at 255).
  - A trigger in ASSERT or RELEASE restarts ASSERT.
- Priority on the same edge: rst_i > SW RST write > soc_fault > INFO write > DRST write. A losing soc_fault is dropped; a losing INFO write is dropped.
- DRST:
  - accepted in RUN only; outside RUN it is responded to but ignored.
  - Each set bit i pulls rst_ob[i] low for STRETCH_CYC cycles, starting the next cycle.
  - Rewriting a bit during its pulse reloads the pulse to the full length.
  - Bits >= N_DOMAIN are ignored. CAUSE and count are unchanged.
- rst_ob[i] = ~(fsm_hold[i] | pulse_active[i]), registered, glitch-free.

Test Plan:
- N_DOMAIN=4, STRETCH=16, STAGGER=4: release rst_i at edge R -> rst_ob 0000 until R+16, then 0001@R+17, 0011@R+21, 0111@R+25, 1111@R+29; CAUSE read = `RST_CAUSE_HW, STAT count = 0.
- In RUN, write RST=0x0001 (2B) -> resp next cycle, rst_ob=0000 next cycle, full staggered release follows; CAUSE=`RST_CAUSE_SW, count=1.
- soc_fault with cause 0x05 and addr 0x8000_0010 on the same edge as an INFO write of 0x1234 -> CAUSE=0x05, INFO=0x8000_0010, count=2.
- DRST=0x4 in RUN -> only rst_ob[2] is low for 16 cycles. A rewrite at cycle 10 extends the low time to 26 total. STAT bit2 reads 1 during the pulse.
- Invalid accesses: read addr 0, 4B access at addr 2, write at addr 12, access at addr 6 -> fault=1 in the same cycle, no resp, no state change.
- Global SW reset issued mid-RELEASE (two domains already released) -> all outputs low next cycle, ASSERT restarts, count increments.

Source files
------------

// File: rtl/rst_sequencer.sv
// Reset sequencer: stretched global assert, staggered per-domain release,
// per-domain software pulses, saturating reset counter, CAUSE/INFO regs.
// Ports: clk, rst_i (async high); rst_ob[N_DOMAIN] active-low domain resets;
// soc_fault/_cause/_addr fault report; bus addr/w_rb/acc/wdata/req in,
// rdata/resp/fault out.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef RST_SIZE
`define RST_SIZE 16
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif
`ifndef RST_CAUSE_HW
`define RST_CAUSE_HW 8'h01
`endif
`ifndef RST_CAUSE_SW
`define RST_CAUSE_SW 8'h02
`endif

module rst_sequencer #(
    parameter int N_DOMAIN    = 4,
    parameter int STRETCH_CYC = 16,
    parameter int STAGGER_CYC = 4
) (
    input  logic                          clk,
    input  logic                          rst_i,
    output logic [N_DOMAIN-1:0]           rst_ob,
    input  logic                          soc_fault,
    input  logic [7:0]                    soc_fault_cause,
    input  logic [`XLEN-1:0]              soc_fault_addr,
    input  logic [$clog2(`RST_SIZE)-1:0]  addr,
    input  logic                          w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0]     acc,
    output logic [`BUS_WIDTH-1:0]         rdata,
    input  logic [`BUS_WIDTH-1:0]         wdata,
    input  logic                          req,
    output logic                          resp,
    output logic                          fault
);

    localparam int AW = $clog2(`RST_SIZE);
    localparam int CW = (STRETCH_CYC > 1) ? $clog2(STRETCH_CYC) : 1;
    localparam int SW = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
    localparam int IW = (N_DOMAIN > 1) ? $clog2(N_DOMAIN) : 1;
    localparam int PW = $clog2(STRETCH_CYC + 1);

    typedef enum logic [1:0] {ASSERT, RELEASE, RUN} state_t;

    state_t                state, state_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic [SW-1:0]         scnt, scnt_d;
    logic [IW-1:0]         idx, idx_d;
    logic [N_DOMAIN-1:0]   rel, rel_d;
    logic [PW-1:0]         pcnt [N_DOMAIN];
    logic [PW-1:0]         pcnt_d [N_DOMAIN];
    logic [N_DOMAIN-1:0]   pact_d;
    logic                  arm, arm_d;
    logic [7:0]            cause, cause_d;
    logic [7:0]            count, count_d;
    logic [`XLEN-1:0]      info, info_d;

    logic a_rst, a_cause, a_info, a_drst, a_stat;
    logic invld, valid;
    logic sw_trig, hw_trig, trig, info_wr, drst_wr;
    logic [`BUS_WIDTH-1:0] rd_val;

    // Address / size / direction decode
    always_comb begin
        a_rst   = (addr == AW'(0));
        a_cause = (addr == AW'(2));
        a_info  = (addr == AW'(4));
        a_drst  = (addr == AW'(8));
        a_stat  = (addr == AW'(12));
        invld   = 1'b1;
        if (a_rst)
            invld = !(acc == `BUS_ACC_2B && w_rb);
        else if (a_cause)
            invld = !(acc == `BUS_ACC_2B && !w_rb);
        else if (a_info)
            invld = (acc != `BUS_ACC_4B);
        else if (a_drst)
            invld = !(acc == `BUS_ACC_4B && w_rb);
        else if (a_stat)
            invld = !(acc == `BUS_ACC_4B && !w_rb);
    end

    assign fault = req & invld;
    assign valid = req & ~invld;

    // Priority: SW reset > soc_fault > INFO write > DRST write
    assign sw_trig = valid & w_rb & a_rst & wdata[0];
    assign hw_trig = soc_fault & ~sw_trig;
    assign trig    = sw_trig | hw_trig;
    assign info_wr = valid & w_rb & a_info & ~soc_fault;
    assign drst_wr = valid & w_rb & a_drst & ~trig & (state == RUN);

    always_comb begin
        rd_val = '0;
        if (a_cause) begin
            rd_val[7:0] = cause;
        end else if (a_info) begin
            rd_val = `BUS_WIDTH'(info);
        end else if (a_stat) begin
            rd_val[N_DOMAIN-1:0] = ~rst_ob;
            rd_val[23:16]        = count;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        scnt_d  = scnt;
        idx_d   = idx;
        rel_d   = rel;
        arm_d   = 1'b0;
        cause_d = cause;
        count_d = count;
        info_d  = info;
        for (int i = 0; i < N_DOMAIN; i++)
            pcnt_d[i] = (pcnt[i] != '0) ? pcnt[i] - PW'(1) : '0;

        unique case (state)
            ASSERT: begin
                // First edge out of rst_i acts as the trigger edge itself
                if (!arm) begin
                    if (cnt == '0) begin
                        state_d = RELEASE;
                        idx_d   = '0;
                        scnt_d  = '0;
                    end else begin
                        cnt_d = cnt - CW'(1);
                    end
                end
            end
            RELEASE: begin
                if (scnt == '0) begin
                    rel_d[idx] = 1'b1;
                    scnt_d     = SW'(STAGGER_CYC - 1);
                    if (idx == IW'(N_DOMAIN - 1))
                        state_d = RUN;
                    else
                        idx_d = idx + IW'(1);
                end else begin
                    scnt_d = scnt - SW'(1);
                end
            end
            RUN: ;
            default: state_d = ASSERT;
        endcase

        if (drst_wr)
            for (int i = 0; i < N_DOMAIN; i++)
                if (wdata[i])
                    pcnt_d[i] = PW'(STRETCH_CYC);

        if (info_wr)
            info_d = `XLEN'(wdata);

        if (trig) begin
            state_d = ASSERT;
            cnt_d   = CW'(STRETCH_CYC - 1);
            rel_d   = '0;
            for (int i = 0; i < N_DOMAIN; i++)
                pcnt_d[i] = '0;
            if (count != 8'hFF)
                count_d = count + 8'd1;
            if (sw_trig) begin
                cause_d = `RST_CAUSE_SW;
            end else begin
                cause_d = soc_fault_cause;
                info_d  = soc_fault_addr;
            end
        end

        for (int i = 0; i < N_DOMAIN; i++)
            pact_d[i] = (pcnt_d[i] != '0);
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state  <= ASSERT;
            cnt    <= CW'(STRETCH_CYC - 1);
            scnt   <= '0;
            idx    <= '0;
            rel    <= '0;
            arm    <= 1'b1;
            cause  <= `RST_CAUSE_HW;
            count  <= '0;
            resp   <= 1'b0;
            rdata  <= '0;
            rst_ob <= '0;
            for (int i = 0; i < N_DOMAIN; i++)
                pcnt[i] <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            scnt   <= scnt_d;
            idx    <= idx_d;
            rel    <= rel_d;
            arm    <= arm_d;
            cause  <= cause_d;
            count  <= count_d;
            resp   <= valid;
            rst_ob <= rel_d & ~pact_d;
            if (valid && !w_rb)
                rdata <= rd_val;
            for (int i = 0; i < N_DOMAIN; i++)
                pcnt[i] <= pcnt_d[i];
        end
    end

    // INFO survives rst_i
    always_ff @(posedge clk)
        info <= info_d;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed self-checking bench for rst_sequencer (4 domains,
// stretch 16, stagger 4).

`ifndef XLEN
`define XLEN 32
`endif
`ifndef RST_SIZE
`define RST_SIZE 16
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif
`ifndef RST_CAUSE_HW
`define RST_CAUSE_HW 8'h01
`endif
`ifndef RST_CAUSE_SW
`define RST_CAUSE_SW 8'h02
`endif

module tb_rst_sequencer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  rst_ob;
    logic        soc_fault;
    logic [7:0]  soc_fault_cause;
    logic [31:0] soc_fault_addr;
    logic [3:0]  addr;
    logic        w_rb;
    logic [1:0]  acc;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic        req;
    logic        resp;
    logic        fault;

    int n_chk = 0;
    int n_fail = 0;

    rst_sequencer #(
        .N_DOMAIN(4),
        .STRETCH_CYC(16),
        .STAGGER_CYC(4)
    ) dut (
        .clk(clk),
        .rst_i(rst_i),
        .rst_ob(rst_ob),
        .soc_fault(soc_fault),
        .soc_fault_cause(soc_fault_cause),
        .soc_fault_addr(soc_fault_addr),
        .addr(addr),
        .w_rb(w_rb),
        .acc(acc),
        .rdata(rdata),
        .wdata(wdata),
        .req(req),
        .resp(resp),
        .fault(fault)
    );

    always #5 clk = ~clk;

    // Expected rst_ob k edges after a trigger edge: domain j high at 17+4j
    function automatic logic [3:0] stag(input int k);
        logic [3:0] r;
        for (int j = 0; j < 4; j++)
            r[j] = (k >= 17 + 4 * j);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input logic w, input logic [3:0] a,
                             input logic [1:0] ac, input logic [31:0] wd);
        req = 1'b1; w_rb = w; addr = a; acc = ac; wdata = wd;
        tick();
        req = 1'b0; w_rb = 1'b0; wdata = '0;
    endtask

    task automatic settle();
        repeat (32) tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #2;
        n_chk++;
        if (rst_ob !== 4'h0 || resp !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_vals: ob=%h resp=%b rd=%h want 0/0/0",
                     rst_ob, resp, rdata);
        end
        repeat (3) tick();
        rst_i = 1'b0;
        for (int k = 0; k <= 30; k++) begin
            tick();
            n_chk++;
            if (rst_ob !== stag(k)) begin
                n_fail++;
                $display("FAIL por_release k=%0d: got %b want %b",
                         k, rst_ob, stag(k));
            end
        end
        do_access(1'b0, 4'd2, `BUS_ACC_2B, 32'h0);
        n_chk++;
        if (rdata !== 32'(`RST_CAUSE_HW) || resp !== 1'b1) begin
            n_fail++;
            $display("FAIL por_cause: got %h resp=%b want %h",
                     rdata, resp, 32'(`RST_CAUSE_HW));
        end
        do_access(1'b0, 4'd12, `BUS_ACC_4B, 32'h0);
        n_chk++;
        if (rdata !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL por_stat: got %h want 00000000", rdata);
        end
    endtask

    task automatic test_info_rw();
        do_access(1'b1, 4'd4, `BUS_ACC_4B, 32'hA5A5_0001);
        n_chk++;
        if (resp !== 1'b1) begin
            n_fail++;
            $display("FAIL info_wr_resp: got %b want 1", resp);
        end
        do_access(1'b0, 4'd4, `BUS_ACC_4B, 32'h0);
        n_chk++;
        if (rdata !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL info_rd: got %h want a5a50001", rdata);
        end
    endtask

    task automatic test_sw_reset();
        do_access(1'b1, 4'd0, `BUS_ACC_2B, 32'h1);
        n_chk++;
        if (resp !== 1'b1 || rst_ob !== 4'h0) begin
            n_fail++;
            $display("FAIL sw_trig: resp=%b ob=%b want 1/0000", resp, rst_ob);
        end
        for (int k = 1; k <= 30; k++) begin
            tick();
            n_chk++;
            if (rst_ob !== stag(k)) begin
                n_fail++;
                $display("FAIL sw_release k=%0d: got %b want %b",
                         k, rst_ob, stag(k));
            end
        end
        do_access(1'b0, 4'd2, `BUS_ACC_2B, 32'h0);
        n_chk++;
        if (rdata !== 32'(`RST_CAUSE_SW)) begin
            n_fail++;
            $display("FAIL sw_cause: got %h want %h",
                     rdata, 32'(`RST_CAUSE_SW));
        end
        do_access(1'b0, 4'd12, `BUS_ACC_4B, 32'h0);
        n_chk++;
        if (rdata !== 32'h0001_0000) begin
            n_fail++;
            $display("FAIL sw_stat: got %h want 00010000", rdata);
        end
    endtask

    task automatic test_fault_info();
        soc_fault = 1'b1;
        soc_fault_cause = 8'h05;
        soc_fault_addr = 32'h8000_0010;
        do_access(1'b1, 4'd4, `BUS_ACC_4B, 32'h0000_1234);
        soc_fault = 1'b0;
        n_chk++;
        if (rst_ob !== 4'h0) begin
            n_fail++;
            $display("FAIL fault_trig: got %b want 0000", rst_ob);
        end
        settle();
        n_chk++;
        if (rst_ob !== 4'hF) begin
            n_fail++;
            $display("FAIL fault_settle: got %b want 1111", rst_ob);
        end
        do_access(1'b0, 4'd2, `BUS_ACC_2B, 32'h0);
        n_chk++;
        if (rdata !== 32'h0000_0005) begin
            n_fail++;
            $display("FAIL fault_cause: got %h want 00000005", rdata);
        end
        do_access(1'b0, 4'd4, `BUS_ACC_4B, 32'h0);
        n_chk++;
        if (rdata !== 32'h8000_0010) begin
            n_fail++;
            $display("FAIL fault_info: got %h want 80000010", rdata);
        end
        do_access(1'b0, 4'd12, `BUS_ACC_4B, 32'h0);
        n_chk++;
        if (rdata !== 32'h0002_0000) begin
            n_fail++;
            $display("FAIL fault_stat: got %h want 00020000", rdata);
        end
    endtask

    task automatic test_drst();
        logic [3:0] e;
        do_access(1'b1, 4'd8, `BUS_ACC_4B, 32'h4);
        n_chk++;
        if (rst_ob !== 4'b1011 || resp !== 1'b1) begin
            n_fail++;
            $display("FAIL drst_start: got %b resp=%b want 1011/1",
                     rst_ob, resp);
        end
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_chk++;
            if (rst_ob !== 4'b1011) begin
                n_fail++;
                $display("FAIL drst_hold k=%0d: got %b want 1011", k, rst_ob);
            end
        end
        do_access(1'b1, 4'd8, `BUS_ACC_4B, 32'h4);
        for (int k = 11; k <= 26; k++) begin
            if (k == 12) begin
                do_access(1'b0, 4'd12, `BUS_ACC_4B, 32'h0);
                n_chk++;
                if (rdata !== 32'h0002_0004) begin
                    n_fail++;
                    $display("FAIL drst_stat: got %h want 00020004", rdata);
                end
            end else begin
                tick();
            end
            e = (k < 26) ? 4'b1011 : 4'b1111;
            n_chk++;
            if (rst_ob !== e) begin
                n_fail++;
                $display("FAIL drst_ext k=%0d: got %b want %b", k, rst_ob, e);
            end
        end
        do_access(1'b1, 4'd8, `BUS_ACC_4B, 32'hF0);
        tick();
        n_chk++;
        if (rst_ob !== 4'b1111) begin
            n_fail++;
            $display("FAIL drst_hibits: got %b want 1111", rst_ob);
        end
    endtask

    task automatic test_invalid();
        logic       cw [5];
        logic [3:0] ca [5];
        logic [1:0] cs [5];
        cw[0] = 1'b0; ca[0] = 4'd0;  cs[0] = `BUS_ACC_2B;
        cw[1] = 1'b0; ca[1] = 4'd2;  cs[1] = `BUS_ACC_4B;
        cw[2] = 1'b1; ca[2] = 4'd12; cs[2] = `BUS_ACC_4B;
        cw[3] = 1'b0; ca[3] = 4'd6;  cs[3] = `BUS_ACC_4B;
        cw[4] = 1'b1; ca[4] = 4'd0;  cs[4] = `BUS_ACC_4B;
        do_access(1'b0, 4'd12, `BUS_ACC_4B, 32'h0);
        for (int i = 0; i < 5; i++) begin
            req = 1'b1; w_rb = cw[i]; addr = ca[i]; acc = cs[i];
            wdata = 32'h1;
            #1;
            n_chk++;
            if (fault !== 1'b1) begin
                n_fail++;
                $display("FAIL inv_fault %0d: got %b want 1", i, fault);
            end
            tick();
            req = 1'b0; w_rb = 1'b0; wdata = '0;
            n_chk++;
            if (resp !== 1'b0 || rst_ob !== 4'hF || rdata !== 32'h0002_0000) begin
                n_fail++;
                $display("FAIL inv_effect %0d: resp=%b ob=%b rd=%h want 0/1111/00020000",
                         i, resp, rst_ob, rdata);
            end
        end
        do_access(1'b0, 4'd2, `BUS_ACC_2B, 32'h0);
        n_chk++;
        if (rdata !== 32'h0000_0005) begin
            n_fail++;
            $display("FAIL inv_cause: got %h want 00000005", rdata);
        end
    endtask

    task automatic test_priority();
        soc_fault = 1'b1;
        soc_fault_cause = 8'h77;
        soc_fault_addr = 32'h0000_DEAD;
        do_access(1'b1, 4'd0, `BUS_ACC_2B, 32'h1);
        soc_fault = 1'b0;
        settle();
        do_access(1'b0, 4'd2, `BUS_ACC_2B, 32'h0);
        n_chk++;
        if (rdata !== 32'(`RST_CAUSE_SW)) begin
            n_fail++;
            $display("FAIL prio_cause: got %h want %h",
                     rdata, 32'(`RST_CAUSE_SW));
        end
        do_access(1'b0, 4'd4, `BUS_ACC_4B, 32'h0);
        n_chk++;
        if (rdata !== 32'h8000_0010) begin
            n_fail++;
            $display("FAIL prio_info: got %h want 80000010", rdata);
        end
        do_access(1'b0, 4'd12, `BUS_ACC_4B, 32'h0);
        n_chk++;
        if (rdata !== 32'h0003_0000) begin
            n_fail++;
            $display("FAIL prio_stat: got %h want 00030000", rdata);
        end
    endtask

    task automatic test_midrelease();
        do_access(1'b1, 4'd0, `BUS_ACC_2B, 32'h1);
        for (int k = 1; k <= 22; k++) begin
            tick();
            n_chk++;
            if (rst_ob !== stag(k)) begin
                n_fail++;
                $display("FAIL mid_pre k=%0d: got %b want %b",
                         k, rst_ob, stag(k));
            end
        end
        do_access(1'b1, 4'd0, `BUS_ACC_2B, 32'h1);
        n_chk++;
        if (rst_ob !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_restart: got %b want 0000", rst_ob);
        end
        for (int k = 1; k <= 30; k++) begin
            tick();
            n_chk++;
            if (rst_ob !== stag(k)) begin
                n_fail++;
                $display("FAIL mid_post k=%0d: got %b want %b",
                         k, rst_ob, stag(k));
            end
        end
        do_access(1'b0, 4'd12, `BUS_ACC_4B, 32'h0);
        n_chk++;
        if (rdata !== 32'h0005_0000) begin
            n_fail++;
            $display("FAIL mid_stat: got %h want 00050000", rdata);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 260; i++)
            do_access(1'b1, 4'd0, `BUS_ACC_2B, 32'h1);
        n_chk++;
        if (rst_ob !== 4'h0 || resp !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_hold: ob=%b resp=%b want 0000/1", rst_ob, resp);
        end
        settle();
        do_access(1'b0, 4'd12, `BUS_ACC_4B, 32'h0);
        n_chk++;
        if (rdata !== 32'h00FF_0000) begin
            n_fail++;
            $display("FAIL b2b_sat: got %h want 00ff0000", rdata);
        end
    endtask

    task automatic test_hw_reset_info();
        rst_i = 1'b1;
        #1;
        n_chk++;
        if (rst_ob !== 4'h0 || resp !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL hw_async: ob=%b resp=%b rd=%h want 0/0/0",
                     rst_ob, resp, rdata);
        end
        repeat (2) tick();
        rst_i = 1'b0;
        settle();
        do_access(1'b0, 4'd4, `BUS_ACC_4B, 32'h0);
        n_chk++;
        if (rdata !== 32'h8000_0010) begin
            n_fail++;
            $display("FAIL hw_info_kept: got %h want 80000010", rdata);
        end
        do_access(1'b0, 4'd2, `BUS_ACC_2B, 32'h0);
        n_chk++;
        if (rdata !== 32'(`RST_CAUSE_HW)) begin
            n_fail++;
            $display("FAIL hw_cause: got %h want %h",
                     rdata, 32'(`RST_CAUSE_HW));
        end
        do_access(1'b0, 4'd12, `BUS_ACC_4B, 32'h0);
        n_chk++;
        if (rdata !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL hw_stat: got %h want 00000000", rdata);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        soc_fault = 1'b0;
        soc_fault_cause = '0;
        soc_fault_addr = '0;
        addr = '0;
        w_rb = 1'b0;
        acc = `BUS_ACC_2B;
        wdata = '0;
        req = 1'b0;
        test_reset();
        test_info_rw();
        test_sw_reset();
        test_fault_info();
        test_drst();
        test_invalid();
        test_priority();
        test_midrelease();
        test_back_to_back();
        test_hw_reset_info();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
